pwl_neuron_mac: RTL and testbench
=================================

Name: pwl_neuron_mac

Overview:
Serial multiply-accumulate neuron that produces the Q8.8 pre-activation values consumed directly by the PWL tanh activation stage.
- Accepts N_INPUTS (x, w) pairs over a valid/ready stream and adds a bias.
- Rounds and saturates the sum to Q8.8, then emits one registered result with a single-cycle valid strobe.
- The y_out/valid_out pair connects straight to the activation stage's x_in/valid_in.

Parameters:
- N_INPUTS, 8, number of (x, w) beats per dot product; legal range 1..256.
- ACC_W, 40, accumulator width in bits; must be >= 33 + clog2(N_INPUTS). Elaboration error if violated.

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  x_in/w_in beat valid
- in_ready  out  1  block can accept a beat this cycle
- x_in  in  16  signed Q8.8 activation input
- w_in  in  16  signed Q8.8 weight
- bias_in  in  16  signed Q8.8 bias; sampled on the first beat of a vector
- valid_out  out  1  one-cycle pulse, y_out valid
- y_out  out  16  signed Q8.8 result: round(sum) saturated
- sat_out  out  1  pulses with valid_out when saturation occurred

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, acc=0, cnt=0.
  - valid_out=0, y_out=0, sat_out=0.
  - Reset mid-vector discards all partial sums; the next accepted beat starts a fresh vector.
- States:
  - IDLE: in_ready=1. Beat accepted (valid_in & in_ready):
    - acc <= sext(bias_in)<<8 + sext(x_in*w_in); cnt<=1.
    - Go to FINAL if N_INPUTS==1, else ACC.
  - ACC: in_ready=1. Beat accepted: acc <= acc + sext(x_in*w_in); cnt<=cnt+1.
    - If cnt==N_INPUTS-1 on an accepted beat, go to FINAL.
    - No beat: hold all state.
  - FINAL: in_ready=0; valid_in is ignored and no beat is consumed. At the next posedge:
    - Register y_out, sat_out and valid_out=1.
    - Return to IDLE, acc<=0, cnt<=0.
- Arithmetic:
  - Product: full 32-bit signed Q16.16, sign-extended to ACC_W. The accumulator never wraps for legal parameters.
  - Rounding: r = (acc + 128) >>> 8 (arithmetic shift, round-half-up toward +inf).
  - Saturation: r>32767 gives y_out=32767, sat_out=1. r<-32768 gives y_out=-32768, sat_out=1. Otherwise y_out=r[15:0], sat_out=0.
- Timing: the last beat is accepted in cycle T. FINAL occupies cycle T+1. valid_out is high for exactly cycle T+2.
- In cycle T+2, in_ready=1 again (IDLE), so a new vector's first beat may be accepted in the same cycle valid_out is high.
- Throughput: N_INPUTS+1 cycles per vector minimum; back-to-back vectors have exactly one bubble (FINAL).
- valid_out is a single-cycle pulse; y_out and sat_out hold their last value until the next pulse or reset.
- Gaps in valid_in at any point in a vector are allowed; the result is identical to a gapless stream.

Test Plan:
- N=4, bias=0, four beats x=256,w=256, no gaps -> valid_out high exactly 2 cycles after the 4th beat is accepted; y_out=1024 (4.0), sat_out=0, in_ready low only in the FINAL cycle.
- Rounding, N=4, bias=0, three zero beats plus one beat:
  - x=1,w=128 -> y_out=1.
  - x=1,w=127 -> y_out=0.
  - x=-1,w=128 -> y_out=0.
  - x=-1,w=129 -> y_out=-1.
- Saturation, N=4, bias=0:
  - All beats x=32767,w=32767 -> y_out=32767, sat_out=1.
  - All beats x=-32768,w=32767 -> y_out=-32768, sat_out=1.
  - Following vector with all zeros -> y_out=0, sat_out=0.
- Bias: bias_in=-75 on the first beat and changed to 500 afterwards, all x=0 -> y_out=-75 (bias sampled only on the first beat).
- Stalls and back-to-back: random valid_in gaps plus valid_in held high through FINAL -> results match the gapless reference. The beat presented during FINAL is not consumed and is accepted next cycle as the first beat of the new vector.
- Reset mid-op: accept 2 beats of x=256,w=256, assert rst for 1 cycle, then send the full vector from the first test -> y_out=1024 with no stale contribution. valid_out stays 0 during and after reset until completion.

Source files
------------

// File: rtl/pwl_neuron_mac.sv
// Serial Q8.8 multiply-accumulate neuron: N_INPUTS (x, w) beats plus a bias,
// rounded half-up and saturated to Q8.8 for the PWL tanh activation stage.
module pwl_neuron_mac #(
    parameter int N_INPUTS = 8,
    parameter int ACC_W    = 40
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_in,
    output logic               in_ready,
    input  logic signed [15:0] x_in,
    input  logic signed [15:0] w_in,
    input  logic signed [15:0] bias_in,
    output logic               valid_out,
    output logic signed [15:0] y_out,
    output logic               sat_out
);

    localparam int CNT_W = $clog2(N_INPUTS + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_INPUTS - 1);
    localparam logic signed [ACC_W-1:0] RND   = ACC_W'(32'sd128);
    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(32'sd32767);
    localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(-32'sd32768);

    generate
        if ((N_INPUTS < 1) || (N_INPUTS > 256) || (ACC_W < 33 + $clog2(N_INPUTS))) begin : g_param_err
            $error("pwl_neuron_mac: N_INPUTS must be 1..256 and ACC_W >= 33 + clog2(N_INPUTS)");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_FINAL = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  w_acc_nxt;
    logic [CNT_W-1:0]         r_cnt;
    logic [CNT_W-1:0]         w_cnt_nxt;
    logic                     r_in_ready;
    logic                     r_valid;
    logic signed [15:0]       r_y;
    logic                     r_sat;
    logic                     w_accept;
    logic                     w_emit;
    logic signed [31:0]       w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_bias_ext;
    logic [16:0]              w_res;

    // Returns {sat, y}: (a + 0.5 LSB) >>> 8, clamped to the signed 16-bit range.
    function automatic logic [16:0] round_sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] r;
        logic [16:0]             res;
        r = (a + RND) >>> 8;
        if (r > Y_MAX) begin
            res = {1'b1, 16'h7FFF};
        end else if (r < Y_MIN) begin
            res = {1'b1, 16'h8000};
        end else begin
            res = {1'b0, r[15:0]};
        end
        return res;
    endfunction

    assign w_prod     = x_in * w_in;
    assign w_prod_ext = {{(ACC_W - 32){w_prod[31]}}, w_prod};
    assign w_bias_ext = {{(ACC_W - 24){bias_in[15]}}, bias_in, 8'h00};
    assign w_accept   = valid_in & r_in_ready;
    assign w_res      = round_sat(r_acc);

    assign in_ready  = r_in_ready;
    assign valid_out = r_valid;
    assign y_out     = r_y;
    assign sat_out   = r_sat;

    // Next-state, accumulator and counter update for the beat/finalise sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_emit      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_acc_nxt   = w_bias_ext + w_prod_ext;
                    w_cnt_nxt   = CNT_ONE;
                    w_state_nxt = (N_INPUTS == 1) ? S_FINAL : S_ACC;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ACC: begin
                if (w_accept) begin
                    w_acc_nxt   = r_acc + w_prod_ext;
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                    w_state_nxt = (r_cnt == CNT_LAST) ? S_FINAL : S_ACC;
                end else begin
                    w_state_nxt = S_ACC;
                end
            end
            S_FINAL: begin
                w_emit      = 1'b1;
                w_acc_nxt   = '0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_acc_nxt   = '0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, accumulator and registered outputs; results only update on the emit cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b1;
            r_valid    <= 1'b0;
            r_y        <= 16'sd0;
            r_sat      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_acc      <= w_acc_nxt;
            r_cnt      <= w_cnt_nxt;
            r_in_ready <= (w_state_nxt != S_FINAL);
            r_valid    <= w_emit;
            if (w_emit) begin
                r_y   <= w_res[15:0];
                r_sat <= w_res[16];
            end
        end
    end

endmodule

// File: tb/tb_pwl_neuron_mac.sv
// Scoreboard bench for pwl_neuron_mac: the driver pushes reference results,
// a negedge monitor pops and compares them whenever valid_out pulses.
module tb_pwl_neuron_mac;

    localparam int N = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               valid_in;
    logic               in_ready;
    logic signed [15:0] x_in;
    logic signed [15:0] w_in;
    logic signed [15:0] bias_in;
    logic               valid_out;
    logic signed [15:0] y_out;
    logic               sat_out;

    always #5 clk = ~clk;

    pwl_neuron_mac #(.N_INPUTS(N), .ACC_W(40)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_in (valid_in),
        .in_ready (in_ready),
        .x_in     (x_in),
        .w_in     (w_in),
        .bias_in  (bias_in),
        .valid_out(valid_out),
        .y_out    (y_out),
        .sat_out  (sat_out)
    );

    typedef struct {
        logic signed [15:0] y;
        logic               sat;
        int                 due;
    } exp_t;

    exp_t               sb_q[$];
    logic signed [15:0] vx[N];
    logic signed [15:0] vw[N];
    int                 cyc = 0;
    int                 n_checks = 0;
    int                 n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: exact integer dot product, floor((sum + 128) / 256), then clamp.
    function automatic exp_t model(input logic signed [15:0] b);
        exp_t   e;
        longint s;
        longint t;
        longint q;
        s = longint'(b) * 256;
        for (int i = 0; i < N; i++) s += longint'(vx[i]) * longint'(vw[i]);
        t = s + 128;
        q = t / 256;
        if ((t % 256 != 0) && (t < 0)) q = q - 1;
        e.sat = 1'b0;
        if (q > 32767) begin
            q = 32767;
            e.sat = 1'b1;
        end else if (q < -32768) begin
            q = -32768;
            e.sat = 1'b1;
        end
        e.y   = 16'(q);
        e.due = 0;
        return e;
    endfunction

    // Monitor: every valid_out pulse must match the oldest pending result.
    always @(negedge clk) begin
        exp_t e;
        if (valid_out === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_valid: valid_out=1 at cycle %0d, expected 0 (nothing pending)", cyc);
            end else begin
                e = sb_q.pop_front();
                check("y_out", longint'(y_out), longint'(e.y));
                check("sat_out", longint'(sat_out), longint'(e.sat));
                check("latency", longint'(cyc), longint'(e.due));
            end
        end
    end

    task automatic idle_cycle();
        valid_in = 1'b0;
        x_in     = 16'($urandom);
        w_in     = 16'($urandom);
        bias_in  = 16'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic signed [15:0] x, input logic signed [15:0] w,
                        input logic signed [15:0] b, output bit ok);
        int waits;
        waits    = 0;
        ok       = 1'b0;
        valid_in = 1'b1;
        x_in     = x;
        w_in     = w;
        bias_in  = b;
        while (!ok && waits < 16) begin
            ok = in_ready;
            @(posedge clk);
            #1;
            waits++;
        end
        if (!ok) check("beat_accept_timeout", 0, 1);
    endtask

    task automatic send_vec(input logic signed [15:0] b, input logic signed [15:0] b_later,
                            input int gap_pct);
        exp_t e;
        bit   ok;
        e = model(b);
        for (int i = 0; i < N; i++) begin
            for (int g = 0; g < 3 && $urandom_range(99) < gap_pct; g++) idle_cycle();
            beat(vx[i], vw[i], (i == 0) ? b : b_later, ok);
            if (!ok) begin
                valid_in = 1'b0;
                return;
            end
        end
        e.due = cyc + 1;
        sb_q.push_back(e);
        check("in_ready_final", longint'(in_ready), 0);
        valid_in = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb_q.size() > 0; k++) begin
            @(posedge clk);
            #1;
        end
        check("drained", longint'(sb_q.size()), 0);
    endtask

    task automatic rand_vec();
        int mode;
        for (int i = 0; i < N; i++) begin
            mode = $urandom_range(2);
            case (mode)
                0: begin
                    vx[i] = 16'($urandom);
                    vw[i] = 16'($urandom);
                end
                1: begin
                    vx[i] = $signed(16'($urandom_range(1023))) - 16'sd512;
                    vw[i] = $signed(16'($urandom_range(1023))) - 16'sd512;
                end
                default: begin
                    vx[i] = $signed(16'($urandom_range(4095))) - 16'sd2048;
                    vw[i] = $signed(16'($urandom_range(511))) - 16'sd256;
                end
            endcase
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int               rx[4];
        int               rw[4];
        bit               ok;
        rx = '{1, 1, -1, -1};
        rw = '{128, 127, 128, 129};

        rst      = 1'b1;
        valid_in = 1'b0;
        x_in     = 16'sd0;
        w_in     = 16'sd0;
        bias_in  = 16'sd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid_out", longint'(valid_out), 0);
        check("reset_y_out", longint'(y_out), 0);
        check("reset_sat_out", longint'(sat_out), 0);
        check("reset_in_ready", longint'(in_ready), 1);
        rst = 1'b0;
        idle_cycle();

        // Basic 4 x (1.0 * 1.0)
        for (int i = 0; i < N; i++) begin
            vx[i] = 16'sd256;
            vw[i] = 16'sd256;
        end
        send_vec(16'sd0, 16'sd0, 0);
        drain();

        // Rounding boundaries
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < N - 1; i++) begin
                vx[i] = 16'sd0;
                vw[i] = 16'($urandom);
            end
            vx[N-1] = 16'(rx[k]);
            vw[N-1] = 16'(rw[k]);
            send_vec(16'sd0, 16'sd0, 0);
        end
        drain();

        // Saturation both ways, then a clean zero vector
        for (int i = 0; i < N; i++) begin
            vx[i] = 16'sd32767;
            vw[i] = 16'sd32767;
        end
        send_vec(16'sd0, 16'sd0, 0);
        for (int i = 0; i < N; i++) vx[i] = -16'sd32768;
        send_vec(16'sd0, 16'sd0, 0);
        for (int i = 0; i < N; i++) begin
            vx[i] = 16'sd0;
            vw[i] = 16'sd0;
        end
        send_vec(16'sd0, 16'sd0, 0);
        drain();

        // Bias sampled on the first beat only
        for (int i = 0; i < N; i++) begin
            vx[i] = 16'sd0;
            vw[i] = 16'($urandom);
        end
        send_vec(-16'sd75, 16'sd500, 0);
        drain();

        // Random vectors with gaps and back-to-back streams
        for (int v = 0; v < 40; v++) begin
            rand_vec();
            send_vec(16'($urandom), 16'($urandom), (v % 3 == 0) ? 0 : 30);
        end
        drain();

        // Reset in the middle of a vector
        beat(16'sd256, 16'sd256, 16'sd0, ok);
        beat(16'sd256, 16'sd256, 16'sd0, ok);
        valid_in = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_valid_out", longint'(valid_out), 0);
        check("midrst_in_ready", longint'(in_ready), 1);
        rst = 1'b0;
        repeat (3) idle_cycle();
        for (int i = 0; i < N; i++) begin
            vx[i] = 16'sd256;
            vw[i] = 16'sd256;
        end
        send_vec(16'sd0, 16'sd0, 0);
        drain();
        repeat (3) idle_cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
